// File: rtl/cfeb_sca_pkg.sv
// ============================================================================
// cfeb_sca_pkg : shared types for the SCA block reader (widths, FSM, entries)
// Revision 1.0
// ============================================================================
`default_nettype none

package cfeb_sca_pkg;

  localparam int BLK_W         = 4;
  localparam int CELL_W        = 3;
  localparam int CELLS_PER_BLK = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    CONV   = 3'd3,
    FREE   = 3'd4
  } state_e;

  typedef struct packed {
    logic             last;
    logic [BLK_W-1:0] adr;
  } blk_entry_t;

endpackage

`default_nettype wire

// File: rtl/sca_blk_fifo.sv
// ============================================================================
// sca_blk_fifo : first-word-fall-through FIFO of block entries
// Revision 1.0
// ============================================================================
`default_nettype none

module sca_blk_fifo
  import cfeb_sca_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic                     rd_i,
  input  blk_entry_t               din_i,
  output blk_entry_t               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  blk_entry_t     mem_q [DEPTH];
  logic [AW-1:0]  wp_q;
  logic [AW-1:0]  rp_q;
  logic [AW:0]    cnt_q;
  logic           w_do_rd;
  logic           w_do_wr;

  // A write into a full queue is legal when the head leaves in the same cycle
  assign w_do_rd = rd_i && !empty_o;
  assign w_do_wr = wr_i && (!full_o || w_do_rd);

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (w_do_wr) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_do_wr) wp_q <= wp_q + AW'(1);
      if (w_do_rd) rp_q <= rp_q + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sca_blk_reader.sv
// ============================================================================
// sca_blk_reader : steps queued SCA blocks cell by cell through ADC converts
// Optional ADC-ack watchdog enabled by macro SCA_RD_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module sca_blk_reader
  import cfeb_sca_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NBLKS      = 12,
  parameter int SETTLE_CYC = 3,
  parameter int TMO_CYC    = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          blk_wr_i,
  input  logic [BLK_W-1:0]              blk_adr_i,
  input  logic                          blk_last_i,
  output logic                          conv_req_o,
  input  logic                          conv_ack_i,
  output logic [BLK_W+CELL_W-1:0]       radr_o,
  output logic                          rd_active_o,
  output logic                          evt_end_o,
  output logic                          fb_stb_o,
  output logic [BLK_W-1:0]              fb_adr_o,
  output logic [$clog2(FIFO_DEPTH):0]   qcnt_o,
  output logic                          ovfl_o,
  output logic                          badr_err_o,
  output logic                          tmo_err_o
);

  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [BLK_W:0] NBLKS_L     = NBLKS[BLK_W:0];

  state_e              state_q;
  logic [BLK_W-1:0]    blk_q;
  logic [CELL_W-1:0]   cell_q;
  logic                last_q;
  logic [3:0]          settle_q;
  logic                conv_req_q;
  logic                fb_stb_q;
  logic                evt_end_q;
  logic [BLK_W-1:0]    fb_adr_q;
  logic                ovfl_q;
  logic                badr_q;

  blk_entry_t          w_head;
  blk_entry_t          w_din;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_bad;
  logic                w_tmo;

  assign w_din = '{last: blk_last_i, adr: blk_adr_i};
  assign w_pop = (state_q == LOAD);
  assign w_bad = ({1'b0, w_head.adr} >= NBLKS_L);

  sca_blk_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (blk_wr_i),
    .rd_i    (w_pop),
    .din_i   (w_din),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .cnt_o   (qcnt_o)
  );

`ifdef SCA_RD_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] wdog_q;
  logic       tmo_q;
  assign w_tmo     = (state_q == CONV) && !conv_ack_i && (wdog_q == TMO_LAST);
  assign tmo_err_o = tmo_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state_q != CONV) wdog_q <= '0;
      else                 wdog_q <= wdog_q + 8'd1;
      if (w_tmo) tmo_q <= 1'b1;
    end
  end
`else
  assign w_tmo     = 1'b0;
  assign tmo_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      cell_q     <= '0;
      last_q     <= 1'b0;
      settle_q   <= '0;
      conv_req_q <= 1'b0;
      fb_stb_q   <= 1'b0;
      evt_end_q  <= 1'b0;
      fb_adr_q   <= '0;
      ovfl_q     <= 1'b0;
      badr_q     <= 1'b0;
    end else begin
      fb_stb_q  <= 1'b0;
      evt_end_q <= 1'b0;
      if (blk_wr_i && w_full && !w_pop) ovfl_q <= 1'b1;
      case (state_q)
        IDLE: if (!w_empty) state_q <= LOAD;
        LOAD: begin
          // A bad address is dropped without touching RADR, so it keeps its last value
          if (w_bad) begin
            badr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            blk_q    <= w_head.adr;
            last_q   <= w_head.last;
            cell_q   <= '0;
            settle_q <= '0;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            conv_req_q <= 1'b1;
            state_q    <= CONV;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        CONV: begin
          if (conv_ack_i || w_tmo) begin
            conv_req_q <= 1'b0;
            if (cell_q == 3'(CELLS_PER_BLK - 1)) begin
              fb_stb_q  <= 1'b1;
              fb_adr_q  <= blk_q;
              evt_end_q <= last_q;
              state_q   <= FREE;
            end else begin
              cell_q   <= cell_q + 3'd1;
              settle_q <= '0;
              state_q  <= SETTLE;
            end
          end
        end
        FREE:    state_q <= w_empty ? IDLE : LOAD;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_req_o  = conv_req_q;
  assign radr_o      = {blk_q, cell_q};
  assign rd_active_o = (state_q != IDLE);
  assign evt_end_o   = evt_end_q;
  assign fb_stb_o    = fb_stb_q;
  assign fb_adr_o    = fb_adr_q;
  assign ovfl_o      = ovfl_q;
  assign badr_err_o  = badr_q;

endmodule

`default_nettype wire
